// File: rtl/config_frame_writer_if.sv
// Bitstream stream and latch-array bus of the configuration frame writer.
// The master side feeds bitstream words; the slave side is the writer itself.
interface config_frame_writer_if #(
    parameter int FRAME_BITS         = 32,
    parameter int FRAME_SELECT_WIDTH = 20
);
    logic [FRAME_BITS-1:0]         WordIn;
    logic                          WordValid;
    logic                          WordReady;
    logic [FRAME_BITS-1:0]         FrameData;
    logic [FRAME_SELECT_WIDTH-1:0] FrameStrobe;
    logic                          Busy;
    logic                          FrameDone;
    logic                          ConfigError;

    modport master (
        output WordIn, WordValid,
        input  WordReady, FrameData, FrameStrobe, Busy, FrameDone, ConfigError
    );

    modport slave (
        input  WordIn, WordValid,
        output WordReady, FrameData, FrameStrobe, Busy, FrameDone, ConfigError
    );
endinterface

// File: rtl/config_frame_writer.sv
// Configuration frame writer for one fabric tile column.
// Hunts for a sync word, decodes frame headers, and writes each data word to
// the latch array with a setup cycle, a multi-cycle one-hot strobe and a hold
// cycle so latch enables never move while FrameData is changing.
module config_frame_writer #(
    parameter int                    FRAME_BITS         = 32,
    parameter int                    FRAME_SELECT_WIDTH = 20,
    parameter int                    STROBE_CYCLES      = 2,
    parameter logic [FRAME_BITS-1:0] SYNC_WORD          = 32'hFAB0_FAB1,
    parameter logic [FRAME_BITS-1:0] DESYNC_WORD        = 32'hFAB0_FAB0
) (
    input logic                  CLK,
    input logic                  RST,
    config_frame_writer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        DATA_WAIT,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
    localparam logic [FRAME_SELECT_WIDTH-1:0] STROBE_LSB =
        {{(FRAME_SELECT_WIDTH-1){1'b0}}, 1'b1};

    state_t                        state;
    logic [FRAME_BITS-1:0]         frame_data;
    logic [FRAME_SELECT_WIDTH-1:0] frame_strobe;
    logic                          frame_done;
    logic                          config_error;
    logic [7:0]                    idx;
    logic [7:0]                    remaining;
    logic [3:0]                    strobe_cnt;

    logic                          word_ready;
    logic                          accept;
    logic [7:0]                    hdr_start;
    logic [7:0]                    hdr_count;
    logic [8:0]                    hdr_end;
    logic                          hdr_bad;

    assign word_ready = !RST && (state == IDLE || state == HEADER || state == DATA_WAIT);
    assign accept     = bus.WordValid && word_ready;

    // Header fields; the end row is computed one bit wider so it cannot wrap.
    assign hdr_start = bus.WordIn[15:8];
    assign hdr_count = bus.WordIn[7:0];
    assign hdr_end   = {1'b0, hdr_start} + {1'b0, hdr_count};
    assign hdr_bad   = (hdr_count == 8'd0) || (hdr_end > 9'(FRAME_SELECT_WIDTH));

    // Frame-writing state machine; all latch-facing outputs are registered here.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            frame_data   <= '0;
            frame_strobe <= '0;
            frame_done   <= 1'b0;
            config_error <= 1'b0;
            idx          <= 8'd0;
            remaining    <= 8'd0;
            strobe_cnt   <= 4'd0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && bus.WordIn == SYNC_WORD) begin
                        config_error <= 1'b0;
                        state        <= HEADER;
                    end
                end
                HEADER: begin
                    if (accept) begin
                        if (bus.WordIn == DESYNC_WORD) begin
                            state <= IDLE;
                        end else if (hdr_bad) begin
                            config_error <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            idx       <= hdr_start;
                            remaining <= hdr_count;
                            state     <= DATA_WAIT;
                        end
                    end
                end
                DATA_WAIT: begin
                    if (accept) begin
                        frame_data <= bus.WordIn;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    frame_strobe <= STROBE_LSB << idx;
                    strobe_cnt   <= 4'd0;
                    state        <= STROBE;
                end
                STROBE: begin
                    if (strobe_cnt == STROBE_LAST) begin
                        frame_strobe <= '0;
                        state        <= HOLD;
                    end else begin
                        strobe_cnt <= strobe_cnt + 4'd1;
                    end
                end
                HOLD: begin
                    frame_done <= 1'b1;
                    idx        <= idx + 8'd1;
                    remaining  <= remaining - 8'd1;
                    state      <= (remaining == 8'd1) ? HEADER : DATA_WAIT;
                end
                default: begin
                    frame_strobe <= '0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    assign bus.WordReady   = word_ready;
    assign bus.FrameData   = frame_data;
    assign bus.FrameStrobe = frame_strobe;
    assign bus.Busy        = !RST && (state != IDLE);
    assign bus.FrameDone   = frame_done;
    assign bus.ConfigError = config_error;

endmodule

// File: tb/tb_config_frame_writer.sv
// Self-checking bench for config_frame_writer: directed scenarios followed by
// randomized header/data sequences, compared against a frame-level model.
module tb_config_frame_writer;

    localparam logic [31:0] SYNC_WORD     = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC_WORD   = 32'hFAB0_FAB0;
    localparam int          ROWS          = 20;
    localparam int          STROBE_CYCLES = 2;

    typedef struct {
        logic [19:0] strobe;
        logic [31:0] data;
        logic [31:0] setup_data;
        logic [31:0] hold_data;
        int          len;
        bit          stable;
    } strobe_event_t;

    typedef struct {
        logic [19:0] strobe;
        logic [31:0] data;
    } frame_exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    config_frame_writer_if bus ();

    config_frame_writer dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    strobe_event_t events[$];
    frame_exp_t    expected[$];
    strobe_event_t cur;
    bit            in_strobe  = 1'b0;
    logic [31:0]   prev_data  = '0;
    int            done_count = 0;
    int            onehot_bad = 0;
    logic [31:0]   last_data  = '0;

    // Free-running configuration clock.
    always #5 CLK = ~CLK;

    // Strobe monitor: records each strobe burst with its setup and hold data.
    always @(negedge CLK) begin
        if (bus.FrameDone === 1'b1) done_count++;
        if (!$onehot0(bus.FrameStrobe)) onehot_bad++;
        if (bus.FrameStrobe != '0) begin
            if (!in_strobe) begin
                in_strobe      = 1'b1;
                cur.strobe     = bus.FrameStrobe;
                cur.data       = bus.FrameData;
                cur.setup_data = prev_data;
                cur.len        = 1;
                cur.stable     = 1'b1;
            end else begin
                cur.len++;
                if (bus.FrameStrobe !== cur.strobe || bus.FrameData !== cur.data)
                    cur.stable = 1'b0;
            end
        end else if (in_strobe) begin
            in_strobe     = 1'b0;
            cur.hold_data = bus.FrameData;
            events.push_back(cur);
        end
        prev_data = bus.FrameData;
    end

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] required);
        tests_run++;
        assert (observed === required) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, required);
        end
    endtask

    // Offers one word and holds it until the writer accepts it.
    task automatic send_word(input logic [31:0] w);
        bit ok;
        ok = 1'b0;
        @(negedge CLK);
        bus.WordIn    = w;
        bus.WordValid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (bus.WordReady === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        @(posedge CLK);
        #1;
        bus.WordValid = 1'b0;
        check_output("word accepted", 64'(ok), 64'd1);
    endtask

    // Model: a valid header yields one strobe per data word on consecutive rows.
    task automatic apply_stimulus(input int start, input int count, input int max_gap);
        logic [19:0] one;
        frame_exp_t  e;
        logic [31:0] w;
        one = 20'd1;
        send_word({1'b0, 15'($urandom), 8'(start), 8'(count)});
        if (count == 0 || start + count > ROWS) return;
        for (int k = 0; k < count; k++) begin
            w = $urandom;
            repeat ($urandom_range(0, max_gap)) @(negedge CLK);
            send_word(w);
            e.strobe = one << (start + k);
            e.data   = w;
            expected.push_back(e);
            last_data = w;
        end
    endtask

    // Waits for the expected strobe bursts, then compares them one by one.
    task automatic check_events(input string tag);
        int cyc;
        cyc = 0;
        while (events.size() < expected.size() && cyc < 1000) begin
            @(posedge CLK);
            cyc++;
        end
        repeat (8) @(posedge CLK);
        check_output({tag, " burst count"}, 64'(events.size()), 64'(expected.size()));
        for (int i = 0; i < events.size() && i < expected.size(); i++) begin
            check_output({tag, " strobe"}, 64'(events[i].strobe), 64'(expected[i].strobe));
            check_output({tag, " data"}, 64'(events[i].data), 64'(expected[i].data));
            check_output({tag, " setup data"}, 64'(events[i].setup_data), 64'(expected[i].data));
            check_output({tag, " hold data"}, 64'(events[i].hold_data), 64'(expected[i].data));
            check_output({tag, " strobe length"}, 64'(events[i].len), 64'(STROBE_CYCLES));
            check_output({tag, " stable"}, 64'(events[i].stable), 64'd1);
        end
        check_output({tag, " done pulses"}, 64'(done_count), 64'(expected.size()));
        events.delete();
        expected.delete();
        done_count = 0;
    endtask

    initial begin
        int          start;
        int          count;
        bit          bad;
        frame_exp_t  e;
        logic [31:0] word_a;

        bus.WordIn    = '0;
        bus.WordValid = 1'b0;

        // Reset values.
        repeat (3) @(negedge CLK);
        check_output("reset WordReady", 64'(bus.WordReady), 64'd0);
        check_output("reset FrameStrobe", 64'(bus.FrameStrobe), 64'd0);
        check_output("reset FrameData", 64'(bus.FrameData), 64'd0);
        check_output("reset Busy", 64'(bus.Busy), 64'd0);
        check_output("reset FrameDone", 64'(bus.FrameDone), 64'd0);
        check_output("reset ConfigError", 64'(bus.ConfigError), 64'd0);
        RST = 1'b0;
        @(posedge CLK);
        events.delete();
        done_count = 0;

        // Non-sync words are consumed and discarded while hunting.
        repeat (5) send_word(32'h1234_5678);
        check_events("hunt");
        check_output("hunt Busy", 64'(bus.Busy), 64'd0);
        check_output("hunt ConfigError", 64'(bus.ConfigError), 64'd0);

        // Two frames at rows 3 and 4.
        send_word(SYNC_WORD);
        check_output("sync Busy", 64'(bus.Busy), 64'd1);
        send_word(32'h0000_0302);
        send_word(32'hDEAD_BEEF);
        send_word(32'h0000_00FF);
        e.strobe = 20'h00008; e.data = 32'hDEAD_BEEF; expected.push_back(e);
        e.strobe = 20'h00010; e.data = 32'h0000_00FF; expected.push_back(e);
        check_events("two frames");
        check_output("back in header Busy", 64'(bus.Busy), 64'd1);
        check_output("back in header ready", 64'(bus.WordReady), 64'd1);
        check_output("data held in header", 64'(bus.FrameData), 64'h0000_00FF);
        last_data = 32'h0000_00FF;

        // Header running past the last row.
        send_word(32'h0000_1305);
        check_events("overrun header");
        check_output("overrun ConfigError", 64'(bus.ConfigError), 64'd1);
        check_output("overrun Busy", 64'(bus.Busy), 64'd0);
        send_word(SYNC_WORD);
        check_output("sync clears error", 64'(bus.ConfigError), 64'd0);

        // Zero-count header, then a clean desync.
        send_word(32'h0000_0500);
        check_events("zero count");
        check_output("zero count ConfigError", 64'(bus.ConfigError), 64'd1);
        send_word(SYNC_WORD);
        send_word(DESYNC_WORD);
        check_output("desync Busy", 64'(bus.Busy), 64'd0);
        check_output("desync ConfigError", 64'(bus.ConfigError), 64'd0);

        // Long stall between two data words.
        word_a = 32'hA5A5_0F0F;
        send_word(SYNC_WORD);
        send_word(32'h0000_0002);
        send_word(word_a);
        e.strobe = 20'h00001; e.data = word_a; expected.push_back(e);
        repeat (STROBE_CYCLES + 4) @(negedge CLK);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check_output("stall FrameStrobe", 64'(bus.FrameStrobe), 64'd0);
            check_output("stall FrameData", 64'(bus.FrameData), 64'(word_a));
        end
        send_word(32'h5A5A_F0F0);
        e.strobe = 20'h00002; e.data = 32'h5A5A_F0F0; expected.push_back(e);
        check_events("stall");
        last_data = 32'h5A5A_F0F0;

        // Randomized header/data sequences, with occasional illegal headers.
        for (int t = 0; t < 10; t++) begin
            bad = ($urandom_range(0, 3) == 0);
            if (bad) begin
                count = $urandom_range(0, 255);
                start = $urandom_range(0, 255);
                if (count != 0 && start + count <= ROWS) count = 0;
            end else begin
                count = $urandom_range(1, 4);
                start = $urandom_range(0, ROWS - count);
            end
            apply_stimulus(start, count, 3);
            check_events("random");
            check_output("random ConfigError", 64'(bus.ConfigError), 64'(bad));
            check_output("random Busy", 64'(bus.Busy), 64'(!bad));
            check_output("random FrameData", 64'(bus.FrameData), 64'(last_data));
            if (bad) send_word(SYNC_WORD);
        end

        // Reset on the first strobe cycle.
        send_word(32'h0000_0001);
        send_word(32'hC0DE_CAFE);
        for (int c = 0; c < 50 && bus.FrameStrobe == '0; c++) @(negedge CLK);
        check_output("strobe reached", 64'(bus.FrameStrobe), 64'h00001);
        RST = 1'b1;
        @(negedge CLK);
        check_output("reset mid-strobe FrameStrobe", 64'(bus.FrameStrobe), 64'd0);
        check_output("reset mid-strobe FrameData", 64'(bus.FrameData), 64'd0);
        check_output("reset mid-strobe Busy", 64'(bus.Busy), 64'd0);
        RST = 1'b0;
        @(posedge CLK);
        events.delete();
        done_count = 0;
        send_word(32'h0000_0001);
        send_word(32'h1111_2222);
        send_word(32'h3333_4444);
        check_events("after reset");
        check_output("after reset Busy", 64'(bus.Busy), 64'd0);
        send_word(SYNC_WORD);
        check_output("resync Busy", 64'(bus.Busy), 64'd1);

        check_output("strobe one-hot", 64'(onehot_bad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
